// File: rtl/regfile_wb_if.sv
// Write-back request bundle between the three producers (ALU, load unit,
// multiply/divide unit) and the register-file write-back arbiter.
//
// Handshake: a requester raises X_valid with X_dst/X_data and keeps all three
// stable until it sees X_ready high in the same cycle. The transfer happens in
// the cycle where X_valid && X_ready. At most one X_ready is high per cycle,
// and X_ready never depends on X_data or X_dst.
//
// Signals per channel X in {alu, ld, mdu}:
//   X_valid  requester -> arbiter  write-back request
//   X_dst    requester -> arbiter  destination register (5 bits)
//   X_data   requester -> arbiter  result (DATA_W bits)
//   X_ready  arbiter -> requester  request granted this cycle
interface regfile_wb_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic [4:0]        alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              ld_valid;
  logic [4:0]        ld_dst;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  logic              mdu_valid;
  logic [4:0]        mdu_dst;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;

  // Requester side.
  modport master (
    output alu_valid, alu_dst, alu_data, input alu_ready,
    output ld_valid,  ld_dst,  ld_data,  input ld_ready,
    output mdu_valid, mdu_dst, mdu_data, input mdu_ready
  );

  // Arbiter side.
  modport slave (
    input alu_valid, alu_dst, alu_data, output alu_ready,
    input ld_valid,  ld_dst,  ld_data,  output ld_ready,
    input mdu_valid, mdu_dst, mdu_data, output mdu_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with pending-write scoreboard.
//
// Shares the single register-file write port between the ALU, the load unit
// and the MDU, and tracks which registers have an issued-but-not-written
// result so decode can stall on RAW/WAW hazards.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wb (slave)          three write-back request channels (valid/dst/data/ready)
//   iss_valid, iss_dst  decode issues an instruction writing iss_dst
//   chk_sel0, chk_sel1  decode source operands to check
//   hazard              a source operand has a pending write (combinational)
//   wr_en/sel/data      registered register-file write port
//
// Arbitration: a LOAD/MDU requester that has waited STARVE_MAX cycles wins;
// a tie between two starved requesters goes to the unit named by the age
// pointer, which flips after every starved grant. Otherwise ALU > LOAD > MDU.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_if.slave       wb,
  input  logic              iss_valid,
  input  logic [4:0]        iss_dst,
  input  logic [4:0]        chk_sel0,
  input  logic [4:0]        chk_sel1,
  output logic              hazard,
  output logic              wr_en,
  output logic [4:0]        wr_sel,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LD   = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;

  typedef enum logic {
    AGE_LD  = 1'b0,
    AGE_MDU = 1'b1
  } age_e;

  // State
  logic [3:0]        ld_cnt_q,  ld_cnt_d;
  logic [3:0]        mdu_cnt_q, mdu_cnt_d;
  age_e              age_q,     age_d;
  logic [31:0]       pend_q,    pend_d;
  logic              wr_en_q,   wr_en_d;
  logic [4:0]        wr_sel_q,  wr_sel_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Arbitration results
  src_e              grant;
  logic              ld_starved;
  logic              mdu_starved;
  logic              starved_grant;
  logic [4:0]        g_dst;
  logic [DATA_W-1:0] g_data;
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;

  // Grant selection. Forced to SRC_NONE in reset so every ready stays low.
  always_comb begin
    ld_starved  = wb.ld_valid  && (ld_cnt_q  == STARVE_LIM);
    mdu_starved = wb.mdu_valid && (mdu_cnt_q == STARVE_LIM);
    grant       = SRC_NONE;
    if (!reset) begin
      if (ld_starved && mdu_starved) begin
        grant = (age_q == AGE_LD) ? SRC_LD : SRC_MDU;
      end else if (ld_starved) begin
        grant = SRC_LD;
      end else if (mdu_starved) begin
        grant = SRC_MDU;
      end else if (wb.alu_valid) begin
        grant = SRC_ALU;
      end else if (wb.ld_valid) begin
        grant = SRC_LD;
      end else if (wb.mdu_valid) begin
        grant = SRC_MDU;
      end
    end
    starved_grant = ((grant == SRC_LD)  && ld_starved) ||
                    ((grant == SRC_MDU) && mdu_starved);
  end

  // Winning payload
  always_comb begin
    g_dst  = 5'd0;
    g_data = '0;
    case (grant)
      SRC_ALU: begin g_dst = wb.alu_dst; g_data = wb.alu_data; end
      SRC_LD:  begin g_dst = wb.ld_dst;  g_data = wb.ld_data;  end
      SRC_MDU: begin g_dst = wb.mdu_dst; g_data = wb.mdu_data; end
      default: begin g_dst = 5'd0;       g_data = '0;          end
    endcase
  end

  assign wb.alu_ready = (grant == SRC_ALU);
  assign wb.ld_ready  = (grant == SRC_LD);
  assign wb.mdu_ready = (grant == SRC_MDU);

  // Next-state logic
  always_comb begin
    // Starvation counters: count ungranted waiting cycles, saturate, and
    // restart from zero on a grant or when the unit has nothing to write.
    ld_cnt_d = 4'd0;
    if (wb.ld_valid && (grant != SRC_LD)) begin
      ld_cnt_d = (ld_cnt_q >= STARVE_LIM) ? STARVE_LIM : ld_cnt_q + 4'd1;
    end
    mdu_cnt_d = 4'd0;
    if (wb.mdu_valid && (grant != SRC_MDU)) begin
      mdu_cnt_d = (mdu_cnt_q >= STARVE_LIM) ? STARVE_LIM : mdu_cnt_q + 4'd1;
    end

    age_d = age_q;
    if (starved_grant) begin
      age_d = (age_q == AGE_LD) ? AGE_MDU : AGE_LD;
    end

    // Scoreboard: apply the clear first so a same-cycle issue re-sets the bit.
    set_vec = iss_valid ? (32'd1 << iss_dst) : 32'd0;
    clr_vec = (grant != SRC_NONE) ? (32'd1 << g_dst) : 32'd0;
    pend_d  = ((pend_q & ~clr_vec) | set_vec) & ~32'd1;

    // Writes to r0 are accepted but never reach the register file; the write
    // port keeps its previous select/data so it only moves on real writes.
    wr_en_d   = (grant != SRC_NONE) && (g_dst != 5'd0);
    wr_sel_d  = wr_en_d ? g_dst  : wr_sel_q;
    wr_data_d = wr_en_d ? g_data : wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt_q  <= 4'd0;
      mdu_cnt_q <= 4'd0;
      age_q     <= AGE_LD;
      pend_q    <= 32'd0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 5'd0;
      wr_data_q <= '0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
      age_q     <= age_d;
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Registered pend only: a clear is visible the cycle wr_en fires, and the
  // register file writes on the falling edge, so no bypass is needed.
  assign hazard = ((chk_sel0 != 5'd0) && pend_q[chk_sel0]) ||
                  ((chk_sel1 != 5'd0) && pend_q[chk_sel1]);

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int SM = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  regfile_wb_if #(.DATA_W(DW)) wb ();
  logic          iss_valid;
  logic [4:0]    iss_dst;
  logic [4:0]    chk_sel0;
  logic [4:0]    chk_sel1;
  logic          hazard;
  logic          wr_en;
  logic [4:0]    wr_sel;
  logic [DW-1:0] wr_data;

  regfile_wb_arbiter #(.DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (wb),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .chk_sel0  (chk_sel0),
    .chk_sel1  (chk_sel1),
    .hazard    (hazard),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: waiting-cycle counts, age owner, pending set, write port.
  int            ld_wait, mdu_wait;
  bit            age_mdu;
  bit            m_pend [32];
  logic          m_wr_en;
  logic [4:0]    m_wr_sel;
  logic [DW-1:0] m_wr_data;
  bit            state_known = 0;

  // Observations of the last cycle
  logic o_alu, o_ld, o_mdu, o_haz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // 0 none, 1 ALU, 2 LOAD, 3 MDU
  function automatic int model_grant();
    bit ls, ms;
    if (reset) return 0;
    ls = wb.ld_valid  && (ld_wait  == SM);
    ms = wb.mdu_valid && (mdu_wait == SM);
    if (ls && ms) return age_mdu ? 3 : 2;
    if (ls) return 2;
    if (ms) return 3;
    if (wb.alu_valid) return 1;
    if (wb.ld_valid)  return 2;
    if (wb.mdu_valid) return 3;
    return 0;
  endfunction

  function automatic bit model_hazard(input logic [4:0] s0, input logic [4:0] s1);
    return (s0 != 0 && m_pend[s0]) || (s1 != 0 && m_pend[s1]);
  endfunction

  task automatic model_update(input int g);
    bit ls, ms;
    logic [4:0]    d;
    logic [DW-1:0] x;
    if (reset) begin
      ld_wait = 0; mdu_wait = 0; age_mdu = 0;
      foreach (m_pend[r]) m_pend[r] = 0;
      m_wr_en = 0; m_wr_sel = 0; m_wr_data = 0;
      state_known = 1;
      return;
    end
    ls = wb.ld_valid  && (ld_wait  == SM);
    ms = wb.mdu_valid && (mdu_wait == SM);
    d = (g == 1) ? wb.alu_dst  : (g == 2) ? wb.ld_dst  : wb.mdu_dst;
    x = (g == 1) ? wb.alu_data : (g == 2) ? wb.ld_data : wb.mdu_data;
    m_wr_en = (g != 0) && (d != 0);
    if (m_wr_en) begin m_wr_sel = d; m_wr_data = x; end
    if (g != 0) m_pend[d] = 0;
    if (iss_valid && iss_dst != 0) m_pend[iss_dst] = 1;
    if ((g == 2 && ls) || (g == 3 && ms)) age_mdu = !age_mdu;
    ld_wait  = (wb.ld_valid  && g != 2) ? ((ld_wait  < SM) ? ld_wait  + 1 : SM) : 0;
    mdu_wait = (wb.mdu_valid && g != 3) ? ((mdu_wait < SM) ? mdu_wait + 1 : SM) : 0;
  endtask

  // One clock: inputs are set at the falling edge by the caller.
  task automatic cycle();
    int g;
    #1;
    g = model_grant();
    o_alu = wb.alu_ready; o_ld = wb.ld_ready; o_mdu = wb.mdu_ready; o_haz = hazard;
    check("alu_ready", wb.alu_ready, g == 1);
    check("ld_ready",  wb.ld_ready,  g == 2);
    check("mdu_ready", wb.mdu_ready, g == 3);
    if (state_known) check("hazard", hazard, model_hazard(chk_sel0, chk_sel1));
    @(posedge clk);
    model_update(g);
    #1;
    if (state_known) begin
      check("wr_en",   wr_en,   m_wr_en);
      check("wr_sel",  wr_sel,  m_wr_sel);
      check("wr_data", wr_data, m_wr_data);
    end
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic drv_alu(input logic v, input logic [4:0] d, input logic [DW-1:0] x);
    wb.alu_valid = v; wb.alu_dst = d; wb.alu_data = x;
  endtask
  task automatic drv_ld(input logic v, input logic [4:0] d, input logic [DW-1:0] x);
    wb.ld_valid = v; wb.ld_dst = d; wb.ld_data = x;
  endtask
  task automatic drv_mdu(input logic v, input logic [4:0] d, input logic [DW-1:0] x);
    wb.mdu_valid = v; wb.mdu_dst = d; wb.mdu_data = x;
  endtask

  // Retire outstanding requests without ever dropping an ungranted valid.
  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (!wb.alu_valid && !wb.ld_valid && !wb.mdu_valid) return;
      cycle();
      if (o_alu) wb.alu_valid = 0;
      if (o_ld)  wb.ld_valid  = 0;
      if (o_mdu) wb.mdu_valid = 0;
    end
    check("drain_timeout", {wb.alu_valid, wb.ld_valid, wb.mdu_valid}, 3'b000);
  endtask

  task automatic do_reset();
    reset = 1; cycle(); reset = 0;
  endtask

  initial begin
    // T1: reset with every requester valid
    reset = 1; iss_valid = 0; iss_dst = 0; chk_sel0 = 0; chk_sel1 = 0;
    drv_alu(1, 5'd3, 32'h11); drv_ld(1, 5'd4, 32'h22); drv_mdu(1, 5'd6, 32'h33);
    @(negedge clk);
    cycle();
    for (int s = 0; s < 32; s++) begin
      chk_sel0 = 5'(s); chk_sel1 = 5'(31 - s);
      #1 check("t1_hazard", hazard, 1'b0);
    end
    chk_sel0 = 0; chk_sel1 = 0;
    cycle();
    check("t1_wr_en", wr_en, 1'b0);
    reset = 0;
    drv_alu(0, 0, 0); drv_ld(0, 0, 0); drv_mdu(0, 0, 0);

    // T2: single ALU write, one-cycle latency
    drv_alu(1, 5'd5, 32'hDEADBEEF);
    cycle();
    check("t2_ready", o_alu, 1'b1);
    check("t2_wr_en", wr_en, 1'b1);
    check("t2_wr_sel", wr_sel, 5'd5);
    check("t2_wr_data", wr_data, 32'hDEADBEEF);
    drv_alu(0, 0, 0);
    cycle();
    check("t2_wr_en_off", wr_en, 1'b0);

    // T3: ALU vs LOAD, LOAD forced in after STARVE_MAX waits and counter restarts
    drv_alu(1, 5'd1, 32'hA1); drv_ld(1, 5'd7, 32'hB7);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t3_ld_grant",  o_ld,  (i == 4) || (i == 9));
      check("t3_alu_grant", o_alu, !((i == 4) || (i == 9)));
    end
    drain();

    // T4a: both starved, age pointer at LOAD after reset
    do_reset();
    drv_alu(1, 5'd2, 32'hC2); drv_ld(1, 5'd8, 32'hD8); drv_mdu(1, 5'd10, 32'hEA);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4a_ld_grant", o_ld, i == 4);
      check("t4a_alu_grant", o_alu, i < 4);
    end
    drain();

    // T4b: LOAD starved grant flips pointer to MDU; next tie goes to MDU
    do_reset();
    drv_alu(1, 5'd2, 32'hC2); drv_ld(1, 5'd8, 32'hD8);
    for (int i = 0; i < 5; i++) cycle();
    check("t4b_ld_first", o_ld, 1'b1);
    drv_mdu(1, 5'd11, 32'hEB);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4b_mdu_tie", o_mdu, i == 4);
    end
    drain();

    // T5: scoreboard set / clear / set-wins
    iss_valid = 1; iss_dst = 5'd9; chk_sel0 = 5'd9; chk_sel1 = 5'd0;
    cycle();
    iss_valid = 0;
    cycle();
    check("t5_hazard_set", o_haz, 1'b1);
    drv_mdu(1, 5'd9, 32'h99);
    cycle();
    check("t5_hazard_during_grant", o_haz, 1'b1);
    drv_mdu(0, 0, 0);
    cycle();
    check("t5_hazard_clr", o_haz, 1'b0);
    iss_valid = 1;
    cycle();
    drv_mdu(1, 5'd9, 32'h9A);
    cycle();
    check("t5_grant_with_issue", o_mdu, 1'b1);
    drv_mdu(0, 0, 0); iss_valid = 0;
    cycle();
    check("t5_set_wins", o_haz, 1'b1);
    drv_alu(1, 5'd9, 32'h9B);
    cycle();
    drv_alu(0, 0, 0);
    cycle();
    check("t5_hazard_clr2", o_haz, 1'b0);

    // T6: register 0
    drv_alu(1, 5'd0, 32'h1);
    cycle();
    check("t6_ready", o_alu, 1'b1);
    check("t6_wr_en", wr_en, 1'b0);
    drv_alu(0, 0, 0);
    iss_valid = 1; iss_dst = 5'd0; chk_sel0 = 5'd0; chk_sel1 = 5'd0;
    cycle();
    iss_valid = 0;
    cycle();
    check("t6_hazard_r0", o_haz, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (!wb.alu_valid && $urandom_range(0, 1) == 1)
        drv_alu(1, 5'($urandom_range(0, 31)), $urandom);
      if (!wb.ld_valid && $urandom_range(0, 1) == 1)
        drv_ld(1, 5'($urandom_range(0, 31)), $urandom);
      if (!wb.mdu_valid && $urandom_range(0, 2) == 0)
        drv_mdu(1, 5'($urandom_range(0, 31)), $urandom);
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_dst   = 5'($urandom_range(0, 31));
      chk_sel0  = 5'($urandom_range(0, 31));
      chk_sel1  = 5'($urandom_range(0, 31));
      if (n == 200) reset = 1;
      cycle();
      reset = 0;
      if (o_alu) wb.alu_valid = 0;
      if (o_ld)  wb.ld_valid  = 0;
      if (o_mdu) wb.mdu_valid = 0;
    end
    iss_valid = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
